// File: rtl/logs_pkg.sv
// Shared definitions for the logs tone path: measurement FSM encodings and
// the largest frequency word an N-bit NCO/meter pair can represent.
package logs_pkg;

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } logs_state_t;

  function automatic int unsigned FREQ_MAX(input int unsigned n);
    return (32'd1 << (n - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/logs_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input; clears to 0
// on synchronous active-low reset.
module logs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the input through the chain every clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/logs_tone_meter.sv
// Square-wave frequency meter: counts rising edges over a 2^N-step gate window
// and returns the count as an NCO frequency word behind a valid/ready handshake.
module logs_tone_meter
  import logs_pkg::*;
#(
  parameter int N           = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         snd_in,
  output logic [N-2:0] freq_out,
  output logic         freq_valid,
  input  logic         freq_ready,
  output logic         overflow,
  output logic         overrun
);

  localparam int unsigned    L_FMAX   = FREQ_MAX(N);
  localparam logic [N-1:0]   L_FMAX_N = N'(L_FMAX);
  localparam logic [N-1:0]   L_ALL1   = {N{1'b1}};
  localparam logic [N-1:0]   L_ONE    = {{(N-1){1'b0}}, 1'b1};

  logic         w_sync;
  logic         w_edge;
  logic         w_win_end;
  logic         w_publish;
  logic         w_xfer;
  logic         w_sat;
  logic [N-1:0] w_cnt;
  logic [N-2:0] w_freq;

  logic         r_prev;
  logic [N-1:0] r_gate;
  logic [N-1:0] r_edges;
  logs_state_t  r_state;
  logic [N-2:0] r_freq;
  logic         r_valid;
  logic         r_ovf;
  logic         r_ovr;

  logs_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (snd_in),
    .o_q   (w_sync)
  );

  // Edge detection, saturating count (window-end edge included) and publish decode.
  always_comb begin
    w_edge    = w_sync & ~r_prev;
    w_win_end = step & (r_gate == L_ALL1);
    w_publish = w_win_end & (r_state == ST_RUN);
    w_xfer    = r_valid & freq_ready;
    if (r_edges == L_ALL1) begin
      w_cnt = r_edges;
    end else begin
      w_cnt = r_edges + {{(N-1){1'b0}}, w_edge};
    end
    w_sat = (w_cnt > L_FMAX_N);
    if (w_sat) begin
      w_freq = L_FMAX_N[N-2:0];
    end else begin
      w_freq = w_cnt[N-2:0];
    end
  end

  // Gate/edge counters and SETTLE/RUN FSM; everything holds while step is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_gate  <= '0;
      r_edges <= '0;
      r_state <= ST_SETTLE;
    end else if (step) begin
      r_prev <= w_sync;
      r_gate <= r_gate + L_ONE;
      if (w_win_end) begin
        r_edges <= '0;
        case (r_state)
          ST_SETTLE: r_state <= ST_RUN;
          ST_RUN:    r_state <= ST_RUN;
          default:   r_state <= ST_SETTLE;
        endcase
      end else begin
        r_edges <= w_cnt;
      end
    end
  end

  // Result register and handshake; a publish takes precedence over a plain transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_freq  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_publish) begin
      r_freq  <= w_freq;
      r_ovf   <= w_sat;
      r_valid <= 1'b1;
      if (r_valid && !freq_ready) begin
        r_ovr <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign freq_out   = r_freq;
  assign freq_valid = r_valid;
  assign overflow   = r_ovf;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_logs_tone_meter.sv
// Directed + randomized bench: an NCO / square-wave source model drives the meter,
// and expected words follow from the edge-count rules (f for an NCO, min(count,15)).
module tb_logs_tone_meter;

  localparam int N    = 5;
  localparam int FMAX = 15;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         step       = 1'b0;
  logic         snd_in     = 1'b0;
  logic         freq_ready = 1'b0;
  logic [N-2:0] freq_out;
  logic         freq_valid;
  logic         overflow;
  logic         overrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Source model state
  int f       = 0;
  int phase   = 0;
  int div     = 1;
  int divc    = 0;
  bit sq_mode = 1'b0;
  bit sq      = 1'b0;

  always #5 clk = ~clk;

  logs_tone_meter #(.N(N), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .snd_in     (snd_in),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .overflow   (overflow),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: present step and source level, advance the source on a step edge.
  task automatic clk1();
    step   = (divc == 0);
    snd_in = sq_mode ? sq : phase[N-1];
    @(posedge clk);
    if (step) begin
      phase = (phase + f) % 32;
      sq    = ~sq;
    end
    divc = (divc + 1) % div;
    #1;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int ncyc);
    ncyc = 0;
    do begin
      clk1();
      ncyc++;
    end while (!freq_valid && ncyc < limit);
    chk({tag, "_arrived"}, int'(freq_valid), 1);
  endtask

  initial begin
    int n;
    int sweep[3] = '{0, 1, 15};

    // Reset state
    freq_ready = 1'b1;
    f = 5;
    repeat (3) clk1();
    chk("rst_valid", int'(freq_valid), 0);
    chk("rst_freq", int'(freq_out), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_ovr", int'(overrun), 0);

    // 1. First result after 64 steps, then one every 32 clocks
    rst_n = 1'b1;
    wait_valid("t1_first", 200, n);
    chk("t1_latency", n, 64);
    chk("t1_freq", int'(freq_out), 5);
    chk("t1_ovf", int'(overflow), 0);
    repeat (3) begin
      wait_valid("t1_next", 100, n);
      chk("t1_period", n, 32);
      chk("t1_freq_n", int'(freq_out), 5);
    end

    // 2. Sweep, then random words; first window after a change may be mixed
    foreach (sweep[i]) begin
      f = sweep[i];
      wait_valid("t2_skip", 100, n);
      wait_valid("t2_meas", 100, n);
      chk("t2_freq", int'(freq_out), f);
      chk("t2_ovf", int'(overflow), 0);
    end
    repeat (4) begin
      f = $urandom_range(0, FMAX);
      wait_valid("rnd_skip", 100, n);
      wait_valid("rnd_meas", 100, n);
      chk("rnd_freq", int'(freq_out), f);
      chk("rnd_ovf", int'(overflow), 0);
    end

    // 3. Consumer stalls across windows -> held value and sticky overrun
    f = 7;
    wait_valid("t3_skip", 100, n);
    wait_valid("t3_meas", 100, n);
    freq_ready = 1'b0;
    repeat (40) clk1();
    chk("t3_valid_held", int'(freq_valid), 1);
    chk("t3_freq_held", int'(freq_out), 7);
    chk("t3_overrun", int'(overrun), 1);
    repeat (40) clk1();
    chk("t3_freq_held2", int'(freq_out), 7);
    chk("t3_overrun2", int'(overrun), 1);
    freq_ready = 1'b1;
    clk1();
    chk("t3_xfer_valid", int'(freq_valid), 0);
    chk("t3_xfer_ovr", int'(overrun), 0);

    // 6. Ready raised on the publish clock
    freq_ready = 1'b0;
    wait_valid("t6_first", 100, n);
    repeat (31) clk1();
    chk("t6_pre_valid", int'(freq_valid), 1);
    chk("t6_pre_ovr", int'(overrun), 0);
    freq_ready = 1'b1;
    clk1();
    chk("t6_valid_kept", int'(freq_valid), 1);
    chk("t6_ovr", int'(overrun), 0);
    chk("t6_freq", int'(freq_out), 7);
    clk1();
    chk("t6_valid_drop", int'(freq_valid), 0);

    // 4. Step every third clock: windows span 96 clocks
    div  = 3;
    divc = 0;
    f    = 9;
    wait_valid("t4_skip", 400, n);
    wait_valid("t4_meas", 400, n);
    chk("t4_freq", int'(freq_out), 9);
    wait_valid("t4_next", 400, n);
    chk("t4_period", n, 96);
    chk("t4_freq_n", int'(freq_out), 9);

    // 5. Square wave toggling every step: 16 edges per window saturates
    div     = 1;
    divc    = 0;
    sq_mode = 1'b1;
    wait_valid("t5_skip", 100, n);
    wait_valid("t5_meas", 100, n);
    chk("t5_freq", int'(freq_out), FMAX);
    chk("t5_ovf", int'(overflow), 1);
    repeat (10) clk1();
    rst_n = 1'b0;
    clk1();
    chk("t5_rst_valid", int'(freq_valid), 0);
    chk("t5_rst_freq", int'(freq_out), 0);
    chk("t5_rst_ovf", int'(overflow), 0);
    chk("t5_rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    wait_valid("t5_after_rst", 200, n);
    chk("t5_latency", n, 64);
    chk("t5_freq2", int'(freq_out), FMAX);
    chk("t5_ovf2", int'(overflow), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
